div16_seq: RTL and testbench



---
 rtl/div16_seq.sv | 152 +++++++++++++++
 tb/tb_div16_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - sequential 16-bit restoring divider, one quotient bit per clock
// Optional signed support is enabled by defining DIV16_SIGNED_EN.

module addsub16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] bx;
    logic        cin;

    // In subtract mode ci acts as a borrow-in, so ci=0 gives a - b and co=1 means no borrow.
    assign bx = sub ? ~b : b;
    assign cin = sub ? ~ci : ci;
    assign {co, s} = {1'b0, a} + {1'b0, bx} + {16'b0, cin};
endmodule

module div16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    input  logic        signed_op,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [15:0] r, q, d;
    logic [15:0] shifted, diff;
    logic        msb_out, co, accept;
    logic [15:0] r_next, q_next;
    logic [15:0] q_load, d_load;

    assign shifted = {r[14:0], q[15]};
    assign msb_out = r[15];

    addsub16 u_addsub (
        .a   (shifted),
        .b   (d),
        .sub (1'b1),
        .ci  (1'b0),
        .s   (diff),
        .co  (co)
    );

    // 17-bit compare: a set bit shifted out of R always exceeds D.
    assign accept = msb_out | co;
    assign r_next = accept ? diff : shifted;
    assign q_next = {q[14:0], accept};

`ifdef DIV16_SIGNED_EN
    logic neg_q, neg_r;
    logic take_sign;

    assign take_sign = signed_op;
    assign q_load = (take_sign && dividend[15]) ? (16'd0 - dividend) : dividend;
    assign d_load = (take_sign && divisor[15]) ? (16'd0 - divisor) : divisor;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign q_load = dividend;
    assign d_load = divisor;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            r           <= 16'd0;
            q           <= 16'd0;
            d           <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 16'd0;
            remainder   <= 16'd0;
            div_by_zero <= 1'b0;
`ifdef DIV16_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == 16'd0) begin
                            quotient    <= 16'hFFFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            r     <= 16'd0;
                            q     <= q_load;
                            d     <= d_load;
                            cnt   <= 4'd0;
                            busy  <= 1'b1;
                            state <= RUN;
`ifdef DIV16_SIGNED_EN
                            neg_q <= take_sign && (dividend[15] ^ divisor[15]);
                            neg_r <= take_sign && dividend[15];
`endif
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
`ifdef DIV16_SIGNED_EN
                        state <= FIX;
`else
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
`endif
                    end
                end
`ifdef DIV16_SIGNED_EN
                FIX: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= neg_q ? (16'd0 - q) : q;
                    remainder   <= neg_r ? (16'd0 - r) : r;
                    div_by_zero <= 1'b0;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div16_seq.sv
// tb/tb_div16_seq.sv - self-checking bench for div16_seq with directed and random divides

module tb_div16_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;

`ifdef DIV16_SIGNED_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    div16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_op   (signed_op),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sg);
        dividend  = a;
        divisor   = b;
        signed_op = sg;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Steps until done, checking busy on the way; exp_n is the expected number of steps.
    task automatic wait_done(input int exp_n, input string tag);
        int  n;
        bit  seen;
        bit  busy_ok;
        seen = 0;
        busy_ok = 1;
        for (n = 0; n < 40; n++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 0;
            step();
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, "_latency"}, n, exp_n);
            check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] eq, input logic [15:0] er,
                                input logic ez);
        check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 16'hFFFF : 16'(int'(a) / int'(b));
    endfunction

    function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? a : 16'(int'(a) % int'(b));
    endfunction

    initial begin
        logic [15:0] a, b;
        bit          extra_done;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = 16'd0;
        divisor   = 16'd0;
        signed_op = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_result("rst", 16'd0, 16'd0, 1'b0);
        rst_n = 1'b1;
        step();

        launch(16'd100, 16'd7, 1'b0);
        wait_done(LAT - 1, "d100_7");
        check_result("d100_7", 16'd14, 16'd2, 1'b0);
        step();
        check("d100_7_done_pulse", {31'd0, done}, 32'd0);
        check("d100_7_hold_q", {16'd0, quotient}, 32'd14);

        launch(16'hFFFF, 16'h8001, 1'b0);
        wait_done(LAT - 1, "dffff_8001");
        check_result("dffff_8001", 16'd1, 16'h7FFE, 1'b0);
        step();

        launch(16'hFFFF, 16'd1, 1'b0);
        wait_done(LAT - 1, "dffff_1");
        check_result("dffff_1", 16'hFFFF, 16'd0, 1'b0);
        step();

        launch(16'h1234, 16'd0, 1'b0);
        wait_done(0, "dzero");
        check_result("dzero", 16'hFFFF, 16'h1234, 1'b1);
        step();
        check("dzero_done_pulse", {31'd0, done}, 32'd0);
        check("dzero_busy", {31'd0, busy}, 32'd0);

        // Ignored start mid-flight, then back-to-back start in the done cycle.
        launch(16'd50, 16'd5, 1'b0);
        repeat (4) step();
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        wait_done(LAT - 6, "b2b_first");
        check_result("b2b_first", 16'd10, 16'd0, 1'b0);
        launch(16'd9, 16'd3, 1'b0);
        check("b2b_hold_q", {16'd0, quotient}, 32'd10);
        wait_done(LAT - 1, "b2b_second");
        check_result("b2b_second", 16'd3, 16'd0, 1'b0);
        step();

        // Reset mid-operation aborts without a done.
        launch(16'd1000, 16'd3, 1'b0);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check_result("abort", 16'd0, 16'd0, 1'b0);
        extra_done = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra_done = 1;
            step();
        end
        check("abort_no_done", {31'd0, extra_done}, 32'd0);
        launch(16'd7, 16'd2, 1'b0);
        wait_done(LAT - 1, "after_abort");
        check_result("after_abort", 16'd3, 16'd1, 1'b0);
        step();

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            case (i % 4)
                0: b = 16'($urandom_range(1, 15));
                1: b = 16'($urandom_range(1, 255));
                2: b = 16'($urandom);
                default: b = (i == 7) ? 16'd0 : 16'($urandom_range(1, 65535));
            endcase
            launch(a, b, 1'b0);
            wait_done((b == 16'd0) ? 0 : LAT - 1, "rand");
            check_result("rand", ref_q(a, b), ref_r(a, b), b == 16'd0);
            step();
            check("rand_done_pulse", {31'd0, done}, 32'd0);
        end

`ifdef DIV16_SIGNED_EN
        launch(16'hFFF9, 16'd2, 1'b1);
        wait_done(LAT - 1, "s_m7_2");
        check_result("s_m7_2", 16'hFFFD, 16'hFFFF, 1'b0);
        step();
        launch(16'd7, 16'hFFFE, 1'b1);
        wait_done(LAT - 1, "s_7_m2");
        check_result("s_7_m2", 16'hFFFD, 16'd1, 1'b0);
        step();
        launch(16'h8000, 16'hFFFF, 1'b1);
        wait_done(LAT - 1, "s_min_m1");
        check_result("s_min_m1", 16'h8000, 16'd0, 1'b0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
